// File: rtl/push_button_event_decoder.sv
// -----------------------------------------------------------------------------
// push_button_event_decoder
//
// Reads eight active-low push buttons from the expansion header. Each button is
// synchronised and debounced. Every clean press becomes a 3-bit key code. The
// codes are queued in a small first-word-fall-through FIFO and handed
// downstream with a valid/ready handshake. The debounced button levels are also
// exported so LED-driving logic can use them directly.
//
// Parameters
//   TICK_DIV       sample-tick period in Clk cycles (>= 2)
//   DEBOUNCE_TICKS consecutive stable ticks needed to accept a change (1..255)
//   FIFO_DEPTH     event queue depth (power of 2, >= 2)
//
// Ports
//   Clk       in   system clock, rising edge
//   Reset     in   asynchronous assert, active-high reset
//   Switch    in   [7:0] raw buttons, active-low, asynchronous to Clk
//   Pressed   out  [7:0] debounced level, 1 = held down
//   KeyCode   out  [2:0] button index at the FIFO head (0 when empty)
//   KeyValid  out  FIFO non-empty
//   KeyReady  in   consumer takes the head entry when KeyValid && KeyReady
//   Overflow  out  sticky flag: a press event was dropped
// -----------------------------------------------------------------------------
module push_button_event_decoder #(
  parameter int TICK_DIV       = 100000,
  parameter int DEBOUNCE_TICKS = 16,
  parameter int FIFO_DEPTH     = 4
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic [7:0] Switch,
  output logic [7:0] Pressed,
  output logic [2:0] KeyCode,
  output logic       KeyValid,
  input  logic       KeyReady,
  output logic       Overflow
);

  localparam int                DIV_W    = $clog2(TICK_DIV);
  localparam logic [DIV_W-1:0]  DIV_LAST = DIV_W'(TICK_DIV - 1);
  localparam logic [7:0]        DB_LIMIT = 8'(DEBOUNCE_TICKS);
  localparam int                PTR_W    = $clog2(FIFO_DEPTH);
  localparam int                CNT_W    = PTR_W + 1;
  localparam logic [CNT_W-1:0]  CNT_FULL = CNT_W'(FIFO_DEPTH);

  // ---------------------------------------------------------------------------
  // Two-flop synchroniser. The flops reset to 1, which is the released level of
  // an active-low button, so no phantom press appears after reset.
  // ---------------------------------------------------------------------------
  logic [7:0] sync1;
  logic [7:0] sync2;
  logic [7:0] level;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      sync1 <= '1;
      sync2 <= '1;
    end else begin
      sync1 <= Switch;
      sync2 <= sync1;
    end
  end

  assign level = ~sync2;

  // ---------------------------------------------------------------------------
  // Sample-tick divider: a one-cycle pulse every TICK_DIV clocks.
  // ---------------------------------------------------------------------------
  logic [DIV_W-1:0] divider;
  logic             tick;

  assign tick = (divider == DIV_LAST);

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      divider <= '0;
    end else if (tick) begin
      divider <= '0;
    end else begin
      divider <= divider + DIV_W'(1);
    end
  end

  // ---------------------------------------------------------------------------
  // Per-button debounce. A counter runs only while the sampled level disagrees
  // with the accepted level. Any agreeing tick restarts the count, so a glitch
  // shorter than DEBOUNCE_TICKS ticks can never flip Pressed.
  // ---------------------------------------------------------------------------
  logic [7:0] db_cnt [8];

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      Pressed <= '0;
      for (int i = 0; i < 8; i++) db_cnt[i] <= '0;
    end else if (tick) begin
      for (int i = 0; i < 8; i++) begin
        if (level[i] == Pressed[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] + 8'd1 == DB_LIMIT) begin
          Pressed[i] <= ~Pressed[i];
          db_cnt[i]  <= '0;
        end else begin
          db_cnt[i]  <= db_cnt[i] + 8'd1;
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Press detection. Only a 0->1 edge of Pressed creates an event. A release
  // creates none.
  // ---------------------------------------------------------------------------
  logic [7:0] pressed_q;
  logic [7:0] rise;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) pressed_q <= '0;
    else       pressed_q <= Pressed;
  end

  assign rise = Pressed & ~pressed_q;

  // ---------------------------------------------------------------------------
  // Pending flags and arbitration. The lowest pending index is written into the
  // FIFO when there is room. Room includes a full FIFO that pops this cycle.
  // ---------------------------------------------------------------------------
  logic [7:0]       pending;
  logic [CNT_W-1:0] count;
  logic             full;
  logic             pop;
  logic             push;
  logic [2:0]       grant_idx;
  logic [7:0]       clr_mask;

  assign KeyValid = (count != '0);
  assign full     = (count == CNT_FULL);
  assign pop      = KeyValid && KeyReady;
  assign push     = (pending != '0) && (!full || pop);

  // NOTE: every combinational output gets a default before any conditional
  // assignment. Otherwise a path that skips the assignment infers a latch.
  always_comb begin
    grant_idx = 3'd0;
    // Scanning downward leaves the lowest set index as the last one written.
    // NOTE: blocking '=' inside always_comb; sequential state uses '<=' only.
    for (int i = 7; i >= 0; i--) begin
      if (pending[i]) grant_idx = 3'(i);
    end
  end

  assign clr_mask = push ? (8'b1 << grant_idx) : 8'b0;

  // A press on a bit whose flag is still pending is lost. The exception is a
  // flag that is being drained this same cycle: the new press then re-arms it.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      pending  <= '0;
      Overflow <= 1'b0;
    end else begin
      pending <= (pending & ~clr_mask) | rise;
      if ((rise & pending & ~clr_mask) != '0) Overflow <= 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // First-word-fall-through event FIFO. The pointers are power-of-two wide, so
  // they wrap on their own.
  // ---------------------------------------------------------------------------
  logic [2:0]       mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;

  // NOTE: the storage array has no reset. Entries are only read while count
  // says they are valid, and KeyCode is forced to 0 when the queue is empty.
  always_ff @(posedge Clk) begin
    if (push) mem[wr_ptr] <= grant_idx;
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  assign KeyCode = KeyValid ? mem[rd_ptr] : 3'd0;

endmodule

// File: tb/tb_push_button_event_decoder.sv
// -----------------------------------------------------------------------------
// Testbench for push_button_event_decoder (TICK_DIV=4, DEBOUNCE_TICKS=3,
// FIFO_DEPTH=4). Stimulus tasks push the expected key codes into a scoreboard
// queue. A separate monitor pops and compares on every accepted handshake.
// -----------------------------------------------------------------------------
module tb_push_button_event_decoder;

  localparam int TICK_DIV       = 4;
  localparam int DEBOUNCE_TICKS = 3;
  localparam int FIFO_DEPTH     = 4;

  logic       clk = 1'b0;
  logic       Reset;
  logic [7:0] Switch;
  logic [7:0] Pressed;
  logic [2:0] KeyCode;
  logic       KeyValid;
  logic       KeyReady;
  logic       Overflow;

  int errors = 0;
  int checks = 0;
  int cycle  = 0;
  int pops   = 0;
  int pop_cycle[$];
  logic [2:0] sb[$];
  logic [7:0] exp_pressed = 8'h00;

  always #5 clk = ~clk;

  push_button_event_decoder #(
    .TICK_DIV      (TICK_DIV),
    .DEBOUNCE_TICKS(DEBOUNCE_TICKS),
    .FIFO_DEPTH    (FIFO_DEPTH)
  ) dut (
    .Clk     (clk),
    .Reset   (Reset),
    .Switch  (Switch),
    .Pressed (Pressed),
    .KeyCode (KeyCode),
    .KeyValid(KeyValid),
    .KeyReady(KeyReady),
    .Overflow(Overflow)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every accepted handshake is compared against the scoreboard head.
  always @(negedge clk) begin : monitor
    logic [2:0] e;
    cycle++;
    if (Reset === 1'b0 && KeyValid === 1'b1 && KeyReady === 1'b1) begin
      pops++;
      pop_cycle.push_back(cycle);
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_event: got KeyCode=%0d expected no event", KeyCode);
      end else begin
        e = sb.pop_front();
        check("event_keycode", 32'(KeyCode), 32'(e));
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Waits a bounded time for Pressed to reach the bench's expected level.
  task automatic wait_pressed(input string name, input int budget);
    int n = 0;
    while (Pressed !== exp_pressed && n < budget) begin
      @(negedge clk);
      n++;
    end
    check(name, 32'(Pressed), 32'(exp_pressed));
    step(1);
  endtask

  task automatic press(input int i);
    Switch[i] = 1'b0;
    exp_pressed[i] = 1'b1;
    wait_pressed("press_level", 40);
  endtask

  task automatic release_btn(input int i);
    Switch[i] = 1'b1;
    exp_pressed[i] = 1'b0;
    wait_pressed("release_level", 40);
  endtask

  // A full press/release. If with_event is set, one event for button i is expected.
  task automatic tap(input int i, input bit with_event);
    if (with_event) sb.push_back(3'(i));
    press(i);
    release_btn(i);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int n;
    int p0;
    Reset    = 1'b1;
    Switch   = 8'hFF;
    KeyReady = 1'b1;
    step(3);
    check("reset_pressed",  32'(Pressed),  32'h00);
    check("reset_keyvalid", 32'(KeyValid), 32'h0);
    check("reset_keycode",  32'(KeyCode),  32'h0);
    check("reset_overflow", 32'(Overflow), 32'h0);
    Reset = 1'b0;
    step(2);

    // 1: single held button, latency and one event, none on release.
    p0 = pops;
    sb.push_back(3'd5);
    Switch[5] = 1'b0;
    exp_pressed = 8'h20;
    n = 0;
    while (Pressed !== 8'h20 && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("t1_pressed", 32'(Pressed), 32'h20);
    check("t1_latency_in_range", 32'(n >= 8 && n <= 18), 32'h1);
    step(6);
    check("t1_one_event", 32'(pops - p0), 32'd1);
    check("t1_keyvalid_low", 32'(KeyValid), 32'h0);
    release_btn(5);
    step(6);
    check("t1_no_release_event", 32'(pops - p0), 32'd1);

    // 2: glitches of two ticks never pass the debouncer.
    p0 = pops;
    for (int k = 0; k < 5; k++) begin
      Switch[2] = 1'b0;
      step(8);
      Switch[2] = 1'b1;
      step(8);
    end
    check("t2_pressed_zero", 32'(Pressed), 32'h00);
    check("t2_no_events", 32'(pops - p0), 32'd0);

    // 3: simultaneous presses are emitted in ascending order on consecutive cycles.
    p0 = pop_cycle.size();
    sb.push_back(3'd1);
    sb.push_back(3'd4);
    sb.push_back(3'd7);
    Switch = 8'h6D;
    exp_pressed = 8'h92;
    wait_pressed("t3_pressed", 40);
    step(6);
    check("t3_three_events", 32'(pop_cycle.size() - p0), 32'd3);
    if (pop_cycle.size() >= p0 + 3) begin
      check("t3_consecutive_a", 32'(pop_cycle[p0+1] - pop_cycle[p0]), 32'd1);
      check("t3_consecutive_b", 32'(pop_cycle[p0+2] - pop_cycle[p0+1]), 32'd1);
    end
    Switch = 8'hFF;
    exp_pressed = 8'h00;
    wait_pressed("t3_released", 40);

    // 4: the fifth press waits in pending while the FIFO is full.
    KeyReady = 1'b0;
    tap(0, 1'b1);
    tap(1, 1'b1);
    tap(2, 1'b1);
    tap(3, 1'b1);
    tap(6, 1'b1);
    step(3);
    check("t4_keyvalid", 32'(KeyValid), 32'h1);
    check("t4_head_stable", 32'(KeyCode), 32'h0);
    check("t4_count_full", 32'(dut.count), 32'd4);
    check("t4_pending6", 32'(dut.pending), 32'h40);
    check("t4_overflow", 32'(Overflow), 32'h0);
    KeyReady = 1'b1;
    step(12);
    check("t4_drained", 32'(sb.size()), 32'd0);
    check("t4_empty", 32'(KeyValid), 32'h0);

    // 5: a second press of a pending button is dropped and flagged.
    KeyReady = 1'b0;
    tap(0, 1'b1);
    tap(1, 1'b1);
    tap(2, 1'b1);
    tap(4, 1'b1);
    tap(3, 1'b1);
    check("t5_pending3", 32'(dut.pending), 32'h08);
    check("t5_no_overflow_yet", 32'(Overflow), 32'h0);
    tap(3, 1'b0);
    step(2);
    check("t5_overflow_set", 32'(Overflow), 32'h1);
    KeyReady = 1'b1;
    step(12);
    check("t5_drained", 32'(sb.size()), 32'd0);
    check("t5_overflow_sticky", 32'(Overflow), 32'h1);
    check("t5_empty", 32'(KeyValid), 32'h0);

    // 6: reset mid-operation, with button 0 still held through it.
    KeyReady = 1'b0;
    tap(1, 1'b1);
    sb.push_back(3'd0);
    press(0);
    step(3);
    check("t6_queued", 32'(dut.count), 32'd2);
    #2;
    Reset = 1'b1;
    #1;
    check("t6_rst_pressed",  32'(Pressed),  32'h00);
    check("t6_rst_keyvalid", 32'(KeyValid), 32'h0);
    check("t6_rst_keycode",  32'(KeyCode),  32'h0);
    check("t6_rst_overflow", 32'(Overflow), 32'h0);
    sb.delete();
    step(2);
    Reset = 1'b0;
    KeyReady = 1'b1;
    sb.push_back(3'd0);
    exp_pressed = 8'h01;
    wait_pressed("t6_redebounce", 40);
    step(6);
    check("t6_fresh_event", 32'(sb.size()), 32'd0);
    release_btn(0);
    step(6);
    check("final_scoreboard_empty", 32'(sb.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/push_button_event_decoder.md
Name: push_button_event_decoder

Overview:
Input-side companion of the LED expansion path. It reads the 8 active-low push buttons on the expansion header and synchronises and debounces each one. Each clean press becomes a 3-bit key code, queued in a small FIFO and handed to downstream logic with a valid/ready handshake. Debounced button levels are also exported for direct use by LED-driving logic.

Parameters:
TICK_DIV, 100000, sample-tick period in Clk cycles (1 kHz at 100 MHz); legal values >= 2.
DEBOUNCE_TICKS, 16, consecutive stable ticks required to accept a level change; legal range 1..255.
FIFO_DEPTH, 4, event queue depth; must be a power of 2, >= 2.

Ports:
Clk  input  1  system clock, rising edge.
Reset  input  1  asynchronous, active-high reset.
Switch  input  8  raw push buttons, active-low, asynchronous to Clk.
Pressed  output  8  debounced level, active-high (1 = held down).
KeyCode  output  3  index of the pressed button at the FIFO head.
KeyValid  output  1  FIFO non-empty; KeyCode is valid.
KeyReady  input  1  consumer accepts the head entry when KeyValid && KeyReady.
Overflow  output  1  sticky: a press event was lost.

Behaviour:
- Reset (async assert, sync release): Pressed=0, KeyValid=0, KeyCode=0, Overflow=0, FIFO empty, pending=0, divider=0, all debounce counters=0, synchroniser flops=1 (released level).
- Synchroniser: 2 flops per bit on Switch. Sampled level s[i] = ~sync2[i].
- Tick: divider counts 0..TICK_DIV-1 and wraps. tick=1 for exactly one cycle when divider==TICK_DIV-1.
- Debounce, per bit i, evaluated only on tick cycles:
  - if s[i]==Pressed[i], counter cleared;
  - otherwise counter increments; when the incremented value reaches DEBOUNCE_TICKS, Pressed[i] toggles and the counter clears.
  - A glitch shorter than DEBOUNCE_TICKS ticks never changes Pressed.
- Press detect: a 0->1 transition of Pressed[i] (registered previous copy) sets pending[i] on the next edge. Release (1->0) generates no event.
- Pending arbitration, every cycle:
  - if pending!=0 and the FIFO will have room this cycle, the lowest set index j is written (KeyCode=j) and pending[j] clears.
  - "Room" means not full, or full with a simultaneous pop (KeyValid && KeyReady).
  - One write per cycle maximum.
- Overflow: set when a press arrives for a bit whose pending flag is already set; that event is dropped. The flag is cleared only by Reset. The press on the pending bit itself is not lost.
- Same-cycle set and clear of pending[j]: set wins (pending stays 1); this is not an overflow.
- FIFO: first-word-fall-through.
  - KeyValid = count!=0; KeyCode = head entry, held stable while KeyValid && !KeyReady.
  - Push and pop in the same cycle leave count unchanged.
  - Pop when empty is ignored.
  - Pointers wrap modulo FIFO_DEPTH; count is $clog2(FIFO_DEPTH)+1 bits.
- Latency: Switch edge -> Pressed change = 2 sync cycles + up to DEBOUNCE_TICKS ticks (+ tick phase). Pressed rise -> pending set 1 cycle -> FIFO write 1 cycle -> KeyValid high 2 cycles after the Pressed edge (FIFO empty, ready).
- Simultaneous presses are enqueued in ascending index order, one per cycle.
- Reset mid-operation discards the queue, pending flags and partial debounce counts immediately. Buttons still held at release are re-debounced and generate fresh press events.

Test Plan:
1. TICK_DIV=4, DEBOUNCE_TICKS=3, KeyReady=1; hold Switch[5]=0 -> Pressed=0x20 after 2+3x4±4 cycles; one event KeyCode=5; KeyValid high one cycle; no event on release.
2. Pulse Switch[2]=0 for 2 ticks then release, repeated 5 times -> Pressed stays 0, KeyValid never asserts.
3. Switch[7],[1],[4] go low in the same cycle -> Pressed=0x92; events KeyCode 1, 4, 7 on consecutive cycles.
4. FIFO_DEPTH=4, KeyReady=0; 5 distinct buttons pressed sequentially -> 4 queued (count=4); 5th held in pending; after one pop it enters the FIFO; Overflow=0.
5. KeyReady=0, FIFO full; press, release, press button 3 while pending[3]=1 -> Overflow=1 and stays 1; exactly one code-3 entry eventually drains.
6. Assert Reset with 2 entries queued and button 0 held -> all outputs 0 immediately. After release: Pressed[0]=1 after re-debounce, and one KeyCode=0 event.
